// File: rtl/axil_ctrl_pkg.sv
// Register map, bit positions and AXI response codes shared by axil_ctrl_regs and its
// AXI-Lite front end.
package axil_ctrl_pkg;
    localparam logic [31:0] OFF_CTRL     = 32'h00;
    localparam logic [31:0] OFF_STATUS   = 32'h04;
    localparam logic [31:0] OFF_CFG0     = 32'h08;
    localparam logic [31:0] OFF_CFG1     = 32'h0C;
    localparam logic [31:0] OFF_SCRATCH  = 32'h10;
    localparam logic [31:0] OFF_DONE_CNT = 32'h14;
    localparam logic [31:0] OFF_VERSION  = 32'h18;

    localparam int BIT_START    = 0;
    localparam int BIT_SOFT_RST = 1;
    localparam int BIT_IRQ_EN   = 2;
    localparam int BIT_BUSY     = 0;
    localparam int BIT_DONE     = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte lanes whose strobe is clear keep their old contents.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        return res;
    endfunction
endpackage

// File: rtl/axil_slave_if.sv
// AXI-Lite slave handshake engine: latches AW/W independently, issues a one-cycle write
// strobe once both are held, and registers read data one cycle after the AR handshake.
module axil_slave_if
    import axil_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_err,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_err
);
    // live_reg keeps every ready low while in reset and for the edge that leaves it.
    logic                    live_reg;
    logic                    aw_held_reg;
    logic                    w_held_reg;
    logic [ADDR_WIDTH-1:0]   awaddr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH/8-1:0] wstrb_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;
    logic                    rvalid_reg;
    logic [1:0]              rresp_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    r_hs;

    assign s_axi_awready = live_reg && !aw_held_reg && !bvalid_reg;
    assign s_axi_wready  = live_reg && !w_held_reg && !bvalid_reg;
    assign s_axi_arready = live_reg && !rvalid_reg;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    assign wr_en   = aw_held_reg && w_held_reg;
    assign wr_addr = awaddr_reg;
    assign wr_data = wdata_reg;
    assign wr_strb = wstrb_reg;
    assign rd_en   = s_axi_arvalid && s_axi_arready;
    assign rd_addr = s_axi_araddr;

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rresp  = rresp_reg;
    assign s_axi_rdata  = rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            live_reg    <= 1'b0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            live_reg <= 1'b1;
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_wdata;
                wstrb_reg  <= s_axi_wstrb;
            end
            // Both phases held: the register bank updates on this edge alongside bvalid.
            if (wr_en) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                bvalid_reg <= 1'b0;
            end
            if (rd_en) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_err ? '0 : rd_data;
                rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_hs) begin
                rvalid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/axil_ctrl_regs.sv
// Control/status register bank of the R4W accelerator behind an AXI-Lite slave.
// Define AXIL_IRQ_EN to build the IRQ_EN bit and the registered DONE interrupt.
module axil_ctrl_regs
    import axil_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] VERSION    = 32'h0001_0000,
    parameter logic [31:0] CFG1_RST   = 32'h0000_0400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  core_busy,
    input  logic                  core_done,
    output logic                  ctrl_start,
    output logic                  ctrl_soft_rst,
    output logic [31:0]           cfg0,
    output logic [31:0]           cfg1,
    output logic                  irq
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_err;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]           rd_data;
    logic                  rd_err;
    logic [31:0]           wr_off;
    logic [31:0]           rd_off;
    logic                  wr_ctrl, wr_status, wr_cfg0, wr_cfg1, wr_scratch;
    logic                  start_hit, soft_hit, done_clr;
    logic                  irq_en;
    logic                  ctrl_start_reg, ctrl_soft_rst_reg, done_reg;
    logic [31:0]           cfg0_reg, cfg1_reg, scratch_reg, done_cnt_reg;
    logic                  unused;

    assign unused = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], rd_addr[1:0], rd_en};

    axil_slave_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_if (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
    );

    // Word-aligned byte offsets so the case items read like the register map.
    assign wr_off = 32'({wr_addr[ADDR_WIDTH-1:2], 2'b00});
    assign rd_off = 32'({rd_addr[ADDR_WIDTH-1:2], 2'b00});

    always_comb begin
        wr_ctrl    = 1'b0;
        wr_status  = 1'b0;
        wr_cfg0    = 1'b0;
        wr_cfg1    = 1'b0;
        wr_scratch = 1'b0;
        wr_err     = 1'b0;
        if (wr_en) begin
            case (wr_off)
                OFF_CTRL:                  wr_ctrl    = 1'b1;
                OFF_STATUS:                wr_status  = 1'b1;
                OFF_CFG0:                  wr_cfg0    = 1'b1;
                OFF_CFG1:                  wr_cfg1    = 1'b1;
                OFF_SCRATCH:               wr_scratch = 1'b1;
                OFF_DONE_CNT, OFF_VERSION: ;
                default:                   wr_err     = 1'b1;
            endcase
        end
    end

    assign start_hit = wr_ctrl && wr_strb[0] && wr_data[BIT_START];
    assign soft_hit  = wr_ctrl && wr_strb[0] && wr_data[BIT_SOFT_RST];
    assign done_clr  = wr_status && wr_strb[0] && wr_data[BIT_DONE];

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_start_reg    <= 1'b0;
            ctrl_soft_rst_reg <= 1'b0;
            cfg0_reg          <= '0;
            cfg1_reg          <= CFG1_RST;
            scratch_reg       <= '0;
            done_reg          <= 1'b0;
            done_cnt_reg      <= '0;
        end else begin
            ctrl_start_reg    <= start_hit;
            ctrl_soft_rst_reg <= soft_hit;
            if (wr_cfg0)    cfg0_reg    <= strb_merge(cfg0_reg, wr_data, wr_strb);
            if (wr_cfg1)    cfg1_reg    <= strb_merge(cfg1_reg, wr_data, wr_strb);
            if (wr_scratch) scratch_reg <= strb_merge(scratch_reg, wr_data, wr_strb);
            // Soft reset beats a coincident core_done; core_done beats a W1C.
            if (soft_hit) begin
                done_reg     <= 1'b0;
                done_cnt_reg <= '0;
            end else if (core_done) begin
                done_reg     <= 1'b1;
                done_cnt_reg <= done_cnt_reg + 32'd1;
            end else if (done_clr) begin
                done_reg <= 1'b0;
            end
        end
    end

`ifdef AXIL_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl && wr_strb[0]) irq_en_reg <= wr_data[BIT_IRQ_EN];
            irq_reg <= done_reg && irq_en_reg;
        end
    end

    assign irq_en = irq_en_reg;
    assign irq    = irq_reg;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_off)
            OFF_CTRL:     rd_data[BIT_IRQ_EN] = irq_en;
            OFF_STATUS: begin
                rd_data[BIT_BUSY] = core_busy;
                rd_data[BIT_DONE] = done_reg;
            end
            OFF_CFG0:     rd_data = cfg0_reg;
            OFF_CFG1:     rd_data = cfg1_reg;
            OFF_SCRATCH:  rd_data = scratch_reg;
            OFF_DONE_CNT: rd_data = done_cnt_reg;
            OFF_VERSION:  rd_data = VERSION;
            default:      rd_err  = 1'b1;
        endcase
    end

    assign ctrl_start    = ctrl_start_reg;
    assign ctrl_soft_rst = ctrl_soft_rst_reg;
    assign cfg0          = cfg0_reg;
    assign cfg1          = cfg1_reg;
endmodule

// File: doc/axil_ctrl_regs.md
Name: axil_ctrl_regs

Overview:
- Synthesizable AXI-Lite slave register file: the control/status front end of an R4W accelerator core.
- Sits directly downstream of the testbench AXI-Lite master BFM and of the PS interconnect in hardware.
- Converts AXI-Lite reads and writes into config registers, start/soft-reset pulses, and sticky status with an optional interrupt.

Parameters:
ADDR_WIDTH, 8, byte address width; decode uses addr[ADDR_WIDTH-1:2].
DATA_WIDTH, 32, data width; only 32 is supported.
VERSION, 32'h0001_0000, value returned by the VERSION register.
CFG1_RST, 32'h0000_0400, reset value of CFG1.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
s_axi_awaddr in ADDR_WIDTH; s_axi_awprot in 3 (ignored); s_axi_awvalid in 1; s_axi_awready out 1
s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1
s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1
s_axi_araddr in ADDR_WIDTH; s_axi_arprot in 3 (ignored); s_axi_arvalid in 1; s_axi_arready out 1
s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1
core_busy  in  1  live busy level from the core
core_done  in  1  one-cycle completion pulse
ctrl_start  out  1  one-cycle start pulse
ctrl_soft_rst  out  1  one-cycle soft-reset pulse
cfg0  out  32  CFG0 register contents
cfg1  out  32  CFG1 register contents
irq  out  1  level interrupt

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 SOFT_RST (write-1 pulse, reads 0); bit2 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO, live core_busy); bit1 DONE (sticky, W1C).
  - 0x08 CFG0: RW, resets to 0.
  - 0x0C CFG1: RW, resets to CFG1_RST.
  - 0x10 SCRATCH: RW, resets to 0.
  - 0x14 DONE_CNT: RO, 32-bit count of core_done pulses; wraps 0xFFFF_FFFF -> 0.
  - 0x18 VERSION: RO.
  - Any other offset: write is dropped with bresp=SLVERR (2'b10); read returns rdata=0 with rresp=SLVERR.
- Writes to RO registers: ignored, bresp=OKAY.
- Reset values: all ready/valid outputs 0, bresp/rresp/rdata 0, ctrl_start 0, ctrl_soft_rst 0, irq 0, cfg0 0, cfg1 CFG1_RST. awready, wready and arready rise the first cycle after rst deasserts.
- Write channel:
  - awready and wready are independent; each is high while its phase is not yet latched and no B response is pending.
  - AW and W may handshake in either order or in the same cycle. Each is latched on its handshake and its ready drops the next cycle.
  - The cycle after both are latched: register update, then bvalid=1 with bresp on the same edge (write latency 1 cycle after the later handshake).
  - bvalid and bresp hold until bready. Both readies re-rise the cycle after the B handshake. One outstanding write.
- WSTRB: byte lanes with strobe 0 are unchanged. START, SOFT_RST, IRQ_EN and DONE W1C act only when wstrb[0]=1.
- Pulses: ctrl_start and ctrl_soft_rst are high for exactly one cycle, on the update cycle.
- SOFT_RST clears DONE and DONE_CNT only; cfg registers and IRQ_EN are kept.
- Read channel:
  - arready is high when rvalid=0.
  - On AR handshake: rdata and rresp are registered and rvalid=1 the next cycle (latency 1).
  - rdata is held stable until the rready handshake; arready re-rises the cycle after. One outstanding read.
  - Read and write paths operate concurrently.
- Simultaneous events:
  - core_done in the same cycle as a DONE W1C: set wins, DONE stays 1 and DONE_CNT increments.
  - core_done in the same cycle as SOFT_RST: clear wins.
- Reset mid-transaction: all valid outputs drop on the reset edge and the pending transaction is discarded.

Optional Feature:
- AXIL_IRQ_EN defined: irq = DONE & IRQ_EN, registered (asserts 1 cycle after DONE sets, deasserts 1 cycle after DONE clears).
- Undefined: irq is tied 0 and IRQ_EN reads 0 (write ignored). All other behaviour is unchanged.

Decomposition:
- Package axil_ctrl_pkg holds:
  - register offset constants and bit-position constants;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- One natural sub-module, axil_slave_if: AW/W/B/AR/R handshake and latching, exposing a single-cycle wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data/rd_err interface to the register bank in the top module.

Test Plan:
- Write 0xDEADBEEF to 0x10, then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF, rresp=OKAY; read 0x18 -> 0x0001_0000.
- AW valid 3 cycles before W, then W before AW; write 0x10 with wstrb=4'b0010, data 0x0000_5500 over 0xDEADBEEF -> reads back 0xDEAD55EF, exactly one B per write.
- Write 0x1 to 0x00 -> ctrl_start high for exactly 1 cycle; read 0x00 -> 0. Write 0x2 -> ctrl_soft_rst pulse, DONE_CNT reads 0.
- Three core_done pulses -> STATUS bit1=1, DONE_CNT=3. Write 0x2 to 0x04 in the same cycle as a core_done pulse -> DONE remains 1, DONE_CNT=4.
- Write/read 0x40 -> bresp=2'b10; rresp=2'b10 with rdata=0. Hold bready/rready low 5 cycles -> bvalid, rvalid and rdata stable, no new AW/AR accepted.
- With AXIL_IRQ_EN, set IRQ_EN then pulse core_done -> irq=1 one cycle after DONE sets; W1C DONE -> irq=0. Assert rst while bvalid=1 -> bvalid=0 and cfg1=0x0000_0400.
